// File: rtl/apb_cmd_master_pkg.sv
// Shared types for the APB command master: FSM states, response record, constants.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } apb_rsp_t;

  localparam logic [3:0] APB_STRB_NONE = 4'b0;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response stream plus APB4 bus signals seen by the command master.
interface apb_cmd_master_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_strb_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic [31:0] paddr_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i;
  logic [31:0] prdata_i;
  logic        pslverr_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  rsp_ready_i,
    output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    input  pready_i, prdata_i, pslverr_i
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output rsp_ready_i,
    input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    output pready_i, prdata_i, pslverr_i
  );
endinterface

// File: rtl/apb_cmd_master_wdog_cnt.sv
// ACCESS wait-cycle counter; expired_o flags the last allowed wait cycle.
module apb_wdog_cnt #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // With TIMEOUT_CYC == 0 the counter may wrap freely; it is never consulted.
  if (TIMEOUT_CYC > 0) begin : g_to
    assign expired_o = inc_i && (cnt_q == CW'(TIMEOUT_CYC - 1));
  end else begin : g_no_to
    assign expired_o = 1'b0;
  end
endmodule

// File: rtl/apb_cmd_master.sv
// APB4 requester: one command in flight, SETUP/ACCESS sequencing, misalign and timeout errors.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              pclk_i,
  input  logic              preset_i,
  apb_cmd_master_if.master  bus
);

  apb_mst_state_t state_q, state_d;
  logic [31:0]    paddr_q, paddr_d;
  logic [31:0]    pwdata_q, pwdata_d;
  logic [3:0]     pstrb_q, pstrb_d;
  logic           pwrite_q, pwrite_d;
  apb_rsp_t       rsp_q, rsp_d;
  logic           wd_exp;

  apb_wdog_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk_i     (pclk_i),
    .rst_i     (preset_i),
    .clr_i     (state_q != ACCESS),
    .inc_i     ((state_q == ACCESS) && !bus.pready_i),
    .expired_o (wd_exp)
  );

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pwrite_d = pwrite_q;
    rsp_d    = rsp_q;
    case (state_q)
      IDLE: if (bus.cmd_valid_i) begin
        // Misaligned commands never touch the bus, so bus registers keep their old values.
        if (is_misaligned(bus.cmd_addr_i[1:0])) begin
          rsp_d   = '{rdata: '0, err: 1'b1, timeout: 1'b0};
          state_d = RESP;
        end else begin
          paddr_d  = bus.cmd_addr_i;
          pwdata_d = bus.cmd_wdata_i;
          pstrb_d  = bus.cmd_write_i ? bus.cmd_strb_i : APB_STRB_NONE;
          pwrite_d = bus.cmd_write_i;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.pready_i) begin
          rsp_d.rdata   = (pwrite_q || bus.pslverr_i) ? '0 : bus.prdata_i;
          rsp_d.err     = bus.pslverr_i;
          rsp_d.timeout = 1'b0;
          state_d       = RESP;
        end else if (wd_exp) begin
          rsp_d   = '{rdata: '0, err: 1'b1, timeout: 1'b1};
          state_d = RESP;
        end
      end
      RESP: if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= APB_STRB_NONE;
      pwrite_q <= 1'b0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      pwrite_q <= pwrite_d;
      rsp_q    <= rsp_d;
    end
  end

  assign bus.cmd_ready_o   = (state_q == IDLE);
  assign bus.rsp_valid_o   = (state_q == RESP);
  assign bus.rsp_rdata_o   = rsp_q.rdata;
  assign bus.rsp_err_o     = rsp_q.err;
  assign bus.rsp_timeout_o = rsp_q.timeout;
  assign bus.psel_o        = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.penable_o     = (state_q == ACCESS);
  assign bus.paddr_o       = paddr_q;
  assign bus.pwrite_o      = pwrite_q;
  assign bus.pwdata_o      = pwdata_q;
  assign bus.pstrb_o       = pstrb_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed scenarios plus randomized transactions.
module tb_apb_cmd_master;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec = 0;
  int   errs = 0;
  logic [31:0] last_addr = '0;

  apb_cmd_master_if bus();

  apb_cmd_master #(.TIMEOUT_CYC(TO)) dut (
    .pclk_i   (clk),
    .preset_i (rst),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = '0;
    bus.cmd_wdata_i = '0;   bus.cmd_strb_i  = '0;   bus.rsp_ready_i = 1'b0;
    bus.pready_i    = 1'b0; bus.prdata_i    = '0;   bus.pslverr_i   = 1'b0;
  endtask

  // Expected outcome from the transfer rules alone: misaligned, timed out, or completed.
  function automatic void ref_model(input logic wr, input logic [31:0] addr, input int waits,
                                    input logic slverr, input logic [31:0] prdata,
                                    output logic [31:0] rdata, output logic err, output logic tmo,
                                    output int acc, output int rsp_cyc);
    if (addr[1:0] != 2'b00) begin
      rdata = '0; err = 1'b1; tmo = 1'b0; acc = 0; rsp_cyc = 1;
    end else if (waits >= TO) begin
      rdata = '0; err = 1'b1; tmo = 1'b1; acc = TO; rsp_cyc = 2 + TO;
    end else begin
      acc = waits + 1; rsp_cyc = 2 + acc; err = slverr; tmo = 1'b0;
      rdata = (wr || slverr) ? '0 : prdata;
    end
  endfunction

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    last_addr = '0;
  endtask

  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int waits, input logic slverr,
                         input logic [31:0] prdata, input int rsp_dly, input logic noise);
    logic [31:0] e_rdata, s_rdata, exp_paddr;
    logic        e_err, e_tmo, s_err, s_tmo, done, aligned;
    int          e_acc, e_cyc, cyc, acc, setup, bad_bus, busy_rdy, got_cyc, unstable;
    ref_model(wr, addr, waits, slverr, prdata, e_rdata, e_err, e_tmo, e_acc, e_cyc);
    aligned = (addr[1:0] == 2'b00);
    vec++;
    if (bus.cmd_ready_o !== 1'b1) begin
      errs++; $display("FAIL idle_ready: got %b want 1", bus.cmd_ready_o);
    end
    bus.cmd_valid_i = 1'b1; bus.cmd_write_i = wr; bus.cmd_addr_i = addr;
    bus.cmd_wdata_i = wdata; bus.cmd_strb_i = strb;
    tick();
    bus.cmd_valid_i = 1'b0;
    cyc = 1; done = 1'b0; acc = 0; setup = 0; bad_bus = 0; busy_rdy = 0; got_cyc = -1;
    while (!done && cyc < 60) begin
      if (bus.rsp_valid_o) begin
        done = 1'b1; got_cyc = cyc;
      end else begin
        if (bus.cmd_ready_o) busy_rdy++;
        bus.pready_i = 1'b0; bus.prdata_i = $urandom(); bus.pslverr_i = 1'($urandom_range(0, 1));
        if (bus.psel_o) begin
          if (bus.paddr_o !== addr || bus.pwrite_o !== wr || bus.pwdata_o !== wdata ||
              bus.pstrb_o !== (wr ? strb : 4'h0)) bad_bus++;
          if (bus.penable_o) begin
            acc++;
            if (acc > waits) begin
              bus.pready_i = 1'b1; bus.prdata_i = prdata; bus.pslverr_i = slverr;
            end
          end else setup++;
        end else if (bus.penable_o) bad_bus++;
        if (noise) begin
          bus.cmd_valid_i = 1'($urandom_range(0, 1)); bus.cmd_addr_i = $urandom();
          bus.cmd_write_i = 1'($urandom_range(0, 1)); bus.rsp_ready_i = 1'($urandom_range(0, 1));
        end
        tick(); cyc++;
      end
    end
    bus.pready_i = 1'b0; bus.pslverr_i = 1'b0; bus.cmd_valid_i = 1'b0; bus.rsp_ready_i = 1'b0;
    vec++;
    if (!done) begin
      errs++; $display("FAIL rsp_wait: got no rsp_valid within 60 cycles, want cycle %0d", e_cyc);
      apply_reset();
      return;
    end
    vec++;
    if (got_cyc != e_cyc) begin errs++; $display("FAIL rsp_cycle: got %0d want %0d", got_cyc, e_cyc); end
    vec++;
    if (acc != e_acc) begin errs++; $display("FAIL access_cycles: got %0d want %0d", acc, e_acc); end
    vec++;
    if (setup != (aligned ? 1 : 0)) begin
      errs++; $display("FAIL setup_cycles: got %0d want %0d", setup, aligned ? 1 : 0);
    end
    vec++;
    if (bad_bus != 0) begin errs++; $display("FAIL bus_fields: got %0d bad cycles want 0", bad_bus); end
    vec++;
    if (busy_rdy != 0) begin errs++; $display("FAIL busy_ready: got %0d ready cycles want 0", busy_rdy); end
    vec++;
    if (bus.rsp_rdata_o !== e_rdata || bus.rsp_err_o !== e_err || bus.rsp_timeout_o !== e_tmo) begin
      errs++; $display("FAIL rsp_fields: got rdata=%h err=%b to=%b want rdata=%h err=%b to=%b",
                       bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o, e_rdata, e_err, e_tmo);
    end
    vec++;
    if (bus.psel_o !== 1'b0 || bus.penable_o !== 1'b0) begin
      errs++; $display("FAIL resp_bus_idle: got psel=%b penable=%b want 0 0", bus.psel_o, bus.penable_o);
    end
    s_rdata = bus.rsp_rdata_o; s_err = bus.rsp_err_o; s_tmo = bus.rsp_timeout_o;
    unstable = 0;
    for (int i = 0; i < rsp_dly; i++) begin
      bus.cmd_valid_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (bus.rsp_valid_o !== 1'b1 || bus.cmd_ready_o !== 1'b0 || bus.rsp_rdata_o !== s_rdata ||
          bus.rsp_err_o !== s_err || bus.rsp_timeout_o !== s_tmo) unstable++;
    end
    vec++;
    if (unstable != 0) begin errs++; $display("FAIL rsp_hold: got %0d unstable cycles want 0", unstable); end
    bus.cmd_valid_i = 1'b0; bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    exp_paddr = aligned ? addr : last_addr;
    vec++;
    if (bus.rsp_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1 || bus.psel_o !== 1'b0) begin
      errs++; $display("FAIL handshake: got rsp_valid=%b cmd_ready=%b psel=%b want 0 1 0",
                       bus.rsp_valid_o, bus.cmd_ready_o, bus.psel_o);
    end
    vec++;
    if (bus.paddr_o !== exp_paddr) begin
      errs++; $display("FAIL paddr_hold: got %h want %h", bus.paddr_o, exp_paddr);
    end
    last_addr = exp_paddr;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.cmd_valid_i = 1'b1; bus.cmd_addr_i = 32'h10; bus.rsp_ready_i = 1'b1;
    rst = 1'b1; tick(); tick();
    vec++;
    if ({bus.psel_o, bus.penable_o, bus.pwrite_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o} !== 6'b0 ||
        bus.paddr_o !== 32'h0 || bus.pwdata_o !== 32'h0 || bus.pstrb_o !== 4'h0 || bus.rsp_rdata_o !== 32'h0) begin
      errs++; $display("FAIL reset_outputs: got psel=%b pen=%b paddr=%h rsp_valid=%b want all 0",
                       bus.psel_o, bus.penable_o, bus.paddr_o, bus.rsp_valid_o);
    end
    vec++;
    if (bus.cmd_ready_o !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready_o); end
    idle_inputs();
    rst = 1'b0;
    last_addr = '0;
    tick();
  endtask

  task automatic test_write_zero_wait();
    run_txn(1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 32'h1234_5678, 0, 1'b0);
  endtask

  task automatic test_read_wait();
    run_txn(1'b0, 32'h4, 32'hA5A5_5A5A, 4'hF, 2, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
  endtask

  task automatic test_slverr();
    run_txn(1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b1, 32'hCAFE_F00D, 0, 1'b0);
  endtask

  task automatic test_misaligned();
    run_txn(1'b1, 32'h2, 32'h1111_2222, 4'h3, 0, 1'b0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 32'h40, 32'h0, 4'h0, TO - 1, 1'b0, 32'h0BAD_F00D, 0, 1'b0);
    run_txn(1'b0, 32'h44, 32'h0, 4'h0, TO, 1'b0, 32'h0BAD_F00D, 0, 1'b0);
  endtask

  task automatic test_rsp_backpressure();
    run_txn(1'b0, 32'h1C, 32'h0, 4'h0, 1, 1'b0, 32'h600D_D00D, 5, 1'b1);
  endtask

  task automatic test_reset_mid();
    int bad;
    bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = 32'h30;
    tick();
    bus.cmd_valid_i = 1'b0;
    tick(); tick();
    vec++;
    if (bus.psel_o !== 1'b1 || bus.penable_o !== 1'b1) begin
      errs++; $display("FAIL mid_access: got psel=%b pen=%b want 1 1", bus.psel_o, bus.penable_o);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    vec++;
    if (bus.psel_o !== 1'b0 || bus.penable_o !== 1'b0) begin
      errs++; $display("FAIL mid_reset_bus: got psel=%b pen=%b want 0 0", bus.psel_o, bus.penable_o);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1 || bus.psel_o !== 1'b0) bad++;
      tick();
    end
    vec++;
    if (bad != 0) begin errs++; $display("FAIL mid_reset_rsp: got %0d bad cycles want 0", bad); end
    last_addr = '0;
  endtask

  task automatic test_random();
    logic [31:0] a, r;
    int w;
    for (int n = 0; n < 40; n++) begin
      a = $urandom(); r = $urandom();
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 2, TO + 4)) : int'($urandom_range(0, 3));
      run_txn(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)), w,
              1'($urandom_range(0, 4) == 0), r, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_misaligned();
    test_timeout();
    test_rsp_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
